bram_bit_serializer_ctrl: RTL
=============================

Name: bram_bit_serializer_ctrl

Overview:
- Controller that uses one 16-Kbit dual-port block RAM (1-bit port A, 16+2-bit port B) as a word-in / bit-out FIFO.
- Producer pushes 16-bit words, which are written through port B.
- Consumer drains the same data one bit per handshake, read through port A.
- The block owns all RAM control pins, pointers, occupancy, flush and the read-latency pipeline; the RAM sits outside it.

Parameters:
- AW, 10, word address width; FIFO depth = 2**AW words (max 10).
- MSB_FIRST, 0, 0 = bit 0 of each word is emitted first; 1 = bit 15 first.
- PARITY_EN, 1, 1 = DIPB carries odd parity per byte; 0 = DIPB driven 2'b00.

Ports:
- CLK  in  1  clock for both RAM ports and all logic.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous flush: empties the FIFO.
- WR_DATA  in  16  word to push.
- WR_VALID  in  1  WR_DATA valid.
- WR_READY  out  1  word accepted when WR_VALID && WR_READY.
- SO_BIT  out  1  serial data bit (= RAM DOA).
- SO_VALID  out  1  SO_BIT valid.
- SO_READY  in  1  consumer takes the bit when SO_VALID && SO_READY.
- SO_LAST  out  1  SO_BIT is the final bit of its word.
- LEVEL  out  AW+1  words stored, counting partially drained words.
- ADDRA  out  14  RAM port A address.
- ENA  out  1  RAM port A enable.
- WEA  out  1  constant 0.
- SSRA  out  1  constant 0.
- DOA  in  1  RAM port A data out (registered inside the RAM, 1-cycle latency).
- ADDRB  out  10  RAM port B address.
- DIB  out  16  RAM port B data.
- DIPB  out  2  RAM port B parity data.
- ENB  out  1  RAM port B enable.
- WEB  out  1  RAM port B write enable.
- SSRB  out  1  constant 0.

Behaviour:
- Reset: async assert on RST_N low. wptr=0, rptr=0 (AW+4 bits: word index plus bit index), cnt=0, SO_VALID=0, SO_LAST=0, WR_READY=0 while RST_N low, LEVEL=0, ENA=ENB=WEB=0.
- Write side:
  - WR_READY = RST_N && (cnt < 2**AW) && !FLUSH, derived only from registered state.
  - On accept: ENB=WEB=1, ADDRB=wptr (zero-extended to 10 bits), DIB=WR_DATA, DIPB={^WR_DATA[15:8]^1, ^WR_DATA[7:0]^1} when PARITY_EN, else 2'b00.
  - wptr wraps modulo 2**AW. Otherwise ENB=WEB=0.
- Read issue:
  - issue = (cnt != 0) && (!SO_VALID || SO_READY) && !FLUSH.
  - On issue: ENA=1, ADDRA={rptr word, bitsel}, where bitsel = rptr bit index (MSB_FIRST=0) or 15-index (MSB_FIRST=1). Then rptr++.
- Read latency:
  - DOA is valid one cycle after issue. SO_VALID is registered: next SO_VALID = issue || (SO_VALID && !SO_READY).
  - SO_LAST is registered with the same timing: 1 when the issued bit index was 15.
  - While SO_VALID && !SO_READY, ENA=0, so the RAM holds DOA and SO_BIT is stable. Bit throughput is 1/cycle under continuous SO_READY.
- Occupancy:
  - cnt increments on a write accept.
  - cnt decrements when bit index 15 of a word is issued. The word is freed at issue, not at consumption.
  - Write and free in the same cycle: cnt unchanged. LEVEL = cnt.
- Full: cnt=2**AW, so WR_READY=0. A slot freed this cycle is writable next cycle; there is no same-cycle bypass.
- Empty: cnt=0, so no issue. SO_VALID falls after the last bit is consumed.
- Read/write ordering: a word written at edge t can be issued at edge t+1 at the earliest, because cnt is registered. Port A and port B therefore never address the same word in the same cycle.
- FLUSH (synchronous, highest priority):
  - wptr, rptr and cnt go to 0; SO_VALID and SO_LAST go to 0 next cycle.
  - Any in-flight bit is discarded.
  - No RAM access occurs in the FLUSH cycle.
- Reset mid-operation: all state returns to reset values immediately. RAM contents are don't-care afterwards.
- Implementation must not use gated clocks or combinational paths from SO_READY to WR_READY.

Test Plan:
- Reset, push 16'hA5C3 (MSB_FIRST=0), SO_READY=1.
  - ENB/WEB pulse with ADDRB=0, DIPB=2'b11 (both bytes have even population, so odd parity sets both bits).
  - First SO_VALID appears 2 cycles after the accept.
  - Bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 appear on consecutive cycles; SO_LAST only on the 16th bit.
  - LEVEL goes 0→1→0, with 0 once the bit-15 read is issued.
- Fill with AW=2 (4 words), SO_READY=0.
  - WR_READY drops after the 4th accept; LEVEL=4.
  - Apply SO_READY=1 for 16 bits: WR_READY rises exactly the cycle after bit index 15 is issued.
  - The 5th word is written to ADDRB=0 (wrap).
- Backpressure: toggle SO_READY pseudo-randomly over 3 words.
  - SO_BIT is held stable while SO_VALID && !SO_READY, and ENA=0 in those cycles.
  - Consumed stream equals the pushed words bit-exact.
  - Repeat with MSB_FIRST=1 and check bit order reversed.
- Simultaneous push and final-bit issue at LEVEL=1: LEVEL stays 1; no lost or duplicated word.
- FLUSH with 2 words queued and SO_VALID=1: next cycle SO_VALID=0, LEVEL=0, WR_READY=1, and ENA/ENB are both 0 in the flush cycle.
- Assert RST_N=0 asynchronously between clock edges mid-word: SO_VALID, LEVEL and ENB are 0 immediately; after release, a pushed word reads out from ADDRA=0.

Source files
------------

// File: rtl/bram_bit_serializer_ctrl.sv
// rtl/bram_bit_serializer_ctrl.sv - word-in / bit-out FIFO controller around an external dual-port block RAM
// Port B writes whole 16-bit words; port A reads them back one bit per handshake.
module bram_bit_serializer_ctrl #(
  parameter int AW        = 10,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          FLUSH,
  input  logic [15:0]   WR_DATA,
  input  logic          WR_VALID,
  output logic          WR_READY,
  output logic          SO_BIT,
  output logic          SO_VALID,
  input  logic          SO_READY,
  output logic          SO_LAST,
  output logic [AW:0]   LEVEL,
  output logic [13:0]   ADDRA,
  output logic          ENA,
  output logic          WEA,
  output logic          SSRA,
  input  logic          DOA,
  output logic [9:0]    ADDRB,
  output logic [15:0]   DIB,
  output logic [1:0]    DIPB,
  output logic          ENB,
  output logic          WEB,
  output logic          SSRB
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW+3:0] rptr;
  logic [AW:0]   cnt;
  logic          so_valid_q;
  logic          so_last_q;
  logic          wr_acc;
  logic          issue;
  logic          issue_last;
  logic [3:0]    bit_idx;
  logic [3:0]    bit_sel;

  assign bit_idx    = rptr[3:0];
  assign bit_sel    = MSB_FIRST ? (4'd15 - bit_idx) : bit_idx;

  // Only registered occupancy feeds WR_READY, so SO_READY never reaches it.
  assign WR_READY   = RST_N && (cnt < FULL) && !FLUSH;
  assign wr_acc     = WR_VALID && WR_READY;

  // A held bit keeps ENA low so the RAM output register stays put.
  assign issue      = (cnt != '0) && (!so_valid_q || SO_READY) && !FLUSH;
  assign issue_last = issue && (bit_idx == 4'd15);

  assign ENA   = issue;
  assign ADDRA = 14'({rptr[AW+3:4], bit_sel});
  assign WEA   = 1'b0;
  assign SSRA  = 1'b0;

  assign ENB   = wr_acc;
  assign WEB   = wr_acc;
  assign ADDRB = 10'(wptr);
  assign DIB   = WR_DATA;
  assign DIPB  = PARITY_EN ? {~^WR_DATA[15:8], ~^WR_DATA[7:0]} : 2'b00;
  assign SSRB  = 1'b0;

  assign SO_BIT   = DOA;
  assign SO_VALID = so_valid_q;
  assign SO_LAST  = so_last_q;
  assign LEVEL    = cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else if (FLUSH) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wptr + 1'b1;
      if (issue)
        rptr <= rptr + 1'b1;
      // A word is freed when its last bit is issued, not when it is consumed.
      if (wr_acc && !issue_last)
        cnt <= cnt + 1'b1;
      else if (!wr_acc && issue_last)
        cnt <= cnt - 1'b1;
      if (issue) begin
        so_valid_q <= 1'b1;
        so_last_q  <= issue_last;
      end else if (SO_READY) begin
        so_valid_q <= 1'b0;
        so_last_q  <= 1'b0;
      end
    end
  end

endmodule
